// File: rtl/datapath_mux_unit_pkg.sv
// Shared select encodings for the CPU datapath muxes.
// The write-back and destination selects have one unused code (11), which is illegal.
package datapath_mux_unit_pkg;

    localparam logic       ALUSRC_REG = 1'b0;
    localparam logic       ALUSRC_IMM = 1'b1;

    localparam logic [1:0] WB_ALU     = 2'b00;
    localparam logic [1:0] WB_MEM     = 2'b01;
    localparam logic [1:0] WB_LINK    = 2'b10;

    localparam logic [1:0] DST_RT     = 2'b00;
    localparam logic [1:0] DST_RD     = 2'b01;
    localparam logic [1:0] DST_RA     = 2'b10;

    localparam logic [1:0] SEL_ILLEGAL = 2'b11;

    // Only a clean binary 11 counts as illegal; X/Z compares unknown and is ignored.
    function automatic logic is_illegal(input logic [1:0] sel);
        return (sel == SEL_ILLEGAL) ? 1'b1 : 1'b0;
    endfunction

endpackage

// File: rtl/datapath_mux_unit.sv
// Datapath operand/write-back/destination muxes with a sticky illegal-select flag.
// Muxes are purely combinational; only sel_err is clocked.
module datapath_mux_unit
    import datapath_mux_unit_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int REG_AW   = 5,
    parameter int LINK_REG = 31
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              alusrc,
    input  logic [DATA_W-1:0] grf_b,
    input  logic [DATA_W-1:0] ext_out,
    output logic [DATA_W-1:0] alusrc_out,
    input  logic [1:0]        datatoreg_sel,
    input  logic [DATA_W-1:0] alu_out,
    input  logic [DATA_W-1:0] dm_data,
    input  logic [DATA_W-1:0] link_addr,
    output logic [DATA_W-1:0] datatoreg_out,
    input  logic [1:0]        regdst_sel,
    input  logic [REG_AW-1:0] rt,
    input  logic [REG_AW-1:0] rd,
    output logic [REG_AW-1:0] reg_rd,
    output logic              sel_err
);

    localparam logic [REG_AW-1:0] LINK_REG_NUM = REG_AW'(LINK_REG);

    logic sel_err_q;
    logic sel_err_d;

    always_comb begin
        alusrc_out = grf_b;
        if (alusrc == ALUSRC_IMM) begin
            alusrc_out = ext_out;
        end
    end

    // Illegal code falls back to the ALU result.
    always_comb begin
        datatoreg_out = alu_out;
        case (datatoreg_sel)
            WB_ALU:  datatoreg_out = alu_out;
            WB_MEM:  datatoreg_out = dm_data;
            WB_LINK: datatoreg_out = link_addr;
            default: datatoreg_out = alu_out;
        endcase
    end

    // Illegal code targets register 0 so the register file drops the write.
    always_comb begin
        reg_rd = '0;
        case (regdst_sel)
            DST_RT:  reg_rd = rt;
            DST_RD:  reg_rd = rd;
            DST_RA:  reg_rd = LINK_REG_NUM;
            default: reg_rd = '0;
        endcase
    end

    always_comb begin
        sel_err_d = sel_err_q;
        if (is_illegal(datatoreg_sel) || is_illegal(regdst_sel)) begin
            sel_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sel_err_q <= 1'b0;
        end else begin
            sel_err_q <= sel_err_d;
        end
    end

    assign sel_err = sel_err_q;

endmodule

// File: tb/tb_datapath_mux_unit.sv
// Randomized self-checking bench for datapath_mux_unit against a table-driven reference model.
module tb_datapath_mux_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        alusrc;
    logic [31:0] grf_b, ext_out, alusrc_out;
    logic [1:0]  datatoreg_sel;
    logic [31:0] alu_out, dm_data, link_addr, datatoreg_out;
    logic [1:0]  regdst_sel;
    logic [4:0]  rt, rd, reg_rd;
    logic        sel_err;

    int n_vec = 0;
    int n_err = 0;
    logic exp_err = 1'b0;

    datapath_mux_unit #(.DATA_W(32), .REG_AW(5), .LINK_REG(31)) dut (
        .clk           (clk),
        .reset         (reset),
        .alusrc        (alusrc),
        .grf_b         (grf_b),
        .ext_out       (ext_out),
        .alusrc_out    (alusrc_out),
        .datatoreg_sel (datatoreg_sel),
        .alu_out       (alu_out),
        .dm_data       (dm_data),
        .link_addr     (link_addr),
        .datatoreg_out (datatoreg_out),
        .regdst_sel    (regdst_sel),
        .rt            (rt),
        .rd            (rd),
        .reg_rd        (reg_rd),
        .sel_err       (sel_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    // One cycle: drive on the falling edge, check muxes, clock, check the sticky flag.
    task automatic step(input logic rst, input logic as, input logic [31:0] gb, input logic [31:0] eo,
                        input logic [1:0] wsel, input logic [31:0] alu, input logic [31:0] dm,
                        input logic [31:0] lk, input logic [1:0] dsel, input logic [4:0] rt_v,
                        input logic [4:0] rd_v);
        logic [31:0] wb_tbl [4];
        logic [4:0]  dst_tbl [4];
        @(negedge clk);
        reset = rst; alusrc = as; grf_b = gb; ext_out = eo;
        datatoreg_sel = wsel; alu_out = alu; dm_data = dm; link_addr = lk;
        regdst_sel = dsel; rt = rt_v; rd = rd_v;
        wb_tbl  = '{alu, dm, lk, alu};
        dst_tbl = '{rt_v, rd_v, 5'd31, 5'd0};
        #1;
        check("alusrc_out", alusrc_out, as ? eo : gb);
        check("datatoreg_out", datatoreg_out, wb_tbl[wsel]);
        check("reg_rd", {27'd0, reg_rd}, {27'd0, dst_tbl[dsel]});
        @(posedge clk);
        if (rst) exp_err = 1'b0;
        else if (wsel == 2'b11 || dsel == 2'b11) exp_err = 1'b1;
        #1;
        check("sel_err", {31'd0, sel_err}, {31'd0, exp_err});
    endtask

    initial begin
        reset = 1'b1; alusrc = 1'b0; grf_b = '0; ext_out = '0;
        datatoreg_sel = 2'b00; alu_out = '0; dm_data = '0; link_addr = '0;
        regdst_sel = 2'b00; rt = '0; rd = '0;

        // Reset state
        step(1, 0, 32'h0000_1234, 32'hFFFF_FFF0, 2'b00, 32'h10, 32'hDEADBEEF, 32'h3004, 2'b00, 5'd8, 5'd9);
        // Operand B and write-back/destination code sweeps
        step(0, 0, 32'h0000_1234, 32'hFFFF_FFF0, 2'b00, 32'h10, 32'hDEADBEEF, 32'h3004, 2'b00, 5'd8, 5'd9);
        step(0, 1, 32'h0000_1234, 32'hFFFF_FFF0, 2'b01, 32'h10, 32'hDEADBEEF, 32'h3004, 2'b01, 5'd8, 5'd9);
        step(0, 1, 32'h0000_1234, 32'hFFFF_FFF0, 2'b10, 32'h10, 32'hDEADBEEF, 32'h3004, 2'b10, 5'd8, 5'd9);
        // Illegal destination code for one cycle, then legal codes: flag sticks
        step(0, 0, 32'h0000_1234, 32'hFFFF_FFF0, 2'b00, 32'h10, 32'hDEADBEEF, 32'h3004, 2'b11, 5'd8, 5'd9);
        step(0, 0, 32'h0000_1234, 32'hFFFF_FFF0, 2'b00, 32'h10, 32'hDEADBEEF, 32'h3004, 2'b00, 5'd8, 5'd9);
        step(0, 0, 32'h0000_1234, 32'hFFFF_FFF0, 2'b11, 32'h10, 32'hDEADBEEF, 32'h3004, 2'b01, 5'd8, 5'd9);
        step(0, 0, 32'h0000_1234, 32'hFFFF_FFF0, 2'b10, 32'h10, 32'hDEADBEEF, 32'h3004, 2'b10, 5'd8, 5'd9);
        // Reset beats an illegal write-back code on the same edge, then code re-arms it
        step(1, 0, 32'h0000_1234, 32'hFFFF_FFF0, 2'b11, 32'h10, 32'hDEADBEEF, 32'h3004, 2'b00, 5'd8, 5'd9);
        step(0, 0, 32'h0000_1234, 32'hFFFF_FFF0, 2'b11, 32'h10, 32'hDEADBEEF, 32'h3004, 2'b00, 5'd8, 5'd9);
        step(1, 0, 32'h0000_1234, 32'hFFFF_FFF0, 2'b00, 32'h10, 32'hDEADBEEF, 32'h3004, 2'b00, 5'd8, 5'd9);

        for (int i = 0; i < 400; i++) begin
            logic [1:0] ws, ds;
            ws = ($urandom_range(0, 7) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            ds = ($urandom_range(0, 7) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            step(($urandom_range(0, 15) == 0), 1'($urandom), $urandom, $urandom, ws,
                 $urandom, $urandom, $urandom, ds, 5'($urandom), 5'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/datapath_mux_unit.md
DATAPATH_MUX_UNIT -- requirements
Module: datapath_mux_unit

Interface
REQ-001 Parameter DATA_W, default 32: data width of all datapath operands.
REQ-002 Parameter REG_AW, default 5: register-number width.
REQ-003 Parameter LINK_REG, default 31: register number selected for link writes.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 alusrc  input  1  ALU operand-B select: 0 = register, 1 = extended immediate.
REQ-007 grf_b  input  DATA_W  register file Read Data2.
REQ-008 ext_out  input  DATA_W  sign/zero-extended immediate.
REQ-009 alusrc_out  output  DATA_W  selected ALU operand B.
REQ-010 datatoreg_sel  input  2  write-back source select.
REQ-011 alu_out  input  DATA_W  ALU result.
REQ-012 dm_data  input  DATA_W  data-memory read data.
REQ-013 link_addr  input  DATA_W  return address (PC+4) for link writes.
REQ-014 datatoreg_out  output  DATA_W  selected write-back data.
REQ-015 regdst_sel  input  2  destination-register select.
REQ-016 rt  input  REG_AW  instruction field [20:16].
REQ-017 rd  input  REG_AW  instruction field [15:11].
REQ-018 reg_rd  output  REG_AW  selected write register number.
REQ-019 sel_err  output  1  sticky flag: an illegal select code was sampled.

Function
REQ-020 alusrc_out SHALL be grf_b when alusrc=0 and ext_out when alusrc=1, combinationally, zero latency.
REQ-021 datatoreg_out SHALL be alu_out for code 00, dm_data for 01, link_addr for 10, combinationally.
REQ-022 datatoreg_sel=11 is illegal; datatoreg_out SHALL then be alu_out.
REQ-023 reg_rd SHALL be rt for code 00, rd for 01, LINK_REG (width REG_AW) for 10, combinationally.
REQ-024 regdst_sel=11 is illegal; reg_rd SHALL then be 0 so that writes are discarded by the register file.
REQ-025 All three mux outputs SHALL be independent of clk and reset and SHALL contain no latches.
REQ-026 On a rising clk with reset=0, sel_err SHALL be set to 1 if datatoreg_sel=11 or regdst_sel=11; otherwise it SHALL hold its value.
REQ-027 sel_err SHALL stay 1 until reset; it SHALL not clear when the select codes become legal again.
REQ-028 X/Z on a select input SHALL not be treated as illegal; only the binary code 11 sets sel_err.

Reset
REQ-029 sel_err SHALL reset to 0 on a rising clk with reset=1.
REQ-030 When reset=1 and an illegal code are present on the same edge, reset SHALL win and sel_err SHALL be 0.
REQ-031 Reset SHALL not affect the combinational mux outputs.

Structure
REQ-032 Select encodings SHALL be named constants in the shared CPU package: ALUSRC_REG=0, ALUSRC_IMM=1; WB_ALU=00, WB_MEM=01, WB_LINK=10; DST_RT=00, DST_RD=01, DST_RA=10.
REQ-033 The module SHALL be flat, with one always block per mux and one clocked block for sel_err; no sub-module is needed.

Verification
REQ-034 alusrc=0, grf_b=0x0000_1234, ext_out=0xFFFF_FFF0 -> alusrc_out=0x0000_1234; alusrc=1 -> 0xFFFF_FFF0.
REQ-035 alu_out=0x10, dm_data=0xDEADBEEF, link_addr=0x3004; datatoreg_sel=00/01/10/11 -> 0x10 / 0xDEADBEEF / 0x3004 / 0x10.
REQ-036 rt=5'd8, rd=5'd9; regdst_sel=00/01/10/11 -> reg_rd=8 / 9 / 31 / 0.
REQ-037 reset pulse, then regdst_sel=11 for one cycle, then legal codes -> sel_err=1 from that edge onward; a reset edge returns it to 0.
REQ-038 reset=1 with datatoreg_sel=11 on the same edge -> sel_err=0; the next edge with reset=0 and the code still 11 -> sel_err=1.
